// File: rtl/move_pkg.sv
// Shared definitions for ant move bookkeeping: move code encodings and move-stack FSM states.
package move_pkg;

    localparam int unsigned MOVE_W = 3;

    typedef enum logic [MOVE_W-1:0] {
        MoveN  = 3'd0,
        MoveNe = 3'd1,
        MoveE  = 3'd2,
        MoveSe = 3'd3,
        MoveS  = 3'd4,
        MoveSw = 3'd5,
        MoveW  = 3'd6,
        MoveNw = 3'd7
    } move_e;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StDrain = 1'b1
    } stack_state_e;

    // Opposite direction: the move that undoes m when backtracking.
    function automatic move_e move_reverse(input move_e m);
        return move_e'(m + 3'd4);
    endfunction

endpackage

// File: rtl/move_stack.sv
// LIFO of ant move codes with registered pop port, oldest-first drain stream,
// full/empty status and sticky overflow/underflow flags.
module move_stack
    import move_pkg::*;
#(
    parameter int unsigned W = MOVE_W,
    parameter int unsigned D = 32,
    localparam int unsigned CW = $clog2(D + 1)
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Clear,
    input  logic          Push,
    input  logic [W-1:0]  PushData,
    input  logic          Pop,
    output logic [W-1:0]  PopData,
    output logic          PopValid,
    input  logic          Drain,
    output logic [W-1:0]  DrainData,
    output logic          DrainValid,
    input  logic          DrainReady,
    output logic          DrainDone,
    output logic          Busy,
    output logic [CW-1:0] Count,
    output logic          Full,
    output logic          Empty,
    output logic          Overflow,
    output logic          Underflow
);

    localparam int unsigned AW = (D > 1) ? $clog2(D) : 1;

    stack_state_e  state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [W-1:0]  pop_data_q, pop_data_d;
    logic          pop_valid_q, pop_valid_d;
    logic [W-1:0]  drain_data_q, drain_data_d;
    logic          drain_valid_q, drain_valid_d;
    logic          drain_done_q, drain_done_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic [W-1:0]  mem_q [D];
    logic          we;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic [AW-1:0] top_addr;
    logic          is_full;
    logic          is_empty;
    logic          last_entry;

    always_comb begin
        top_addr      = AW'(count_q - CW'(1));
        is_full       = (count_q == CW'(D));
        is_empty      = (count_q == '0);
        last_entry    = (idx_q == top_addr);

        state_d       = state_q;
        count_d       = count_q;
        idx_d         = idx_q;
        pop_data_d    = pop_data_q;
        pop_valid_d   = 1'b0;
        drain_data_d  = drain_data_q;
        drain_valid_d = drain_valid_q;
        drain_done_d  = 1'b0;
        overflow_d    = overflow_q;
        underflow_d   = underflow_q;
        we            = 1'b0;
        waddr         = AW'(count_q);
        wdata         = PushData;

        unique case (state_q)
            StIdle: begin
                if (Clear) begin
                    count_d     = '0;
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                end else if (Drain) begin
                    if (!is_empty) begin
                        state_d       = StDrain;
                        idx_d         = '0;
                        drain_valid_d = 1'b1;
                        drain_data_d  = mem_q[0];
                    end else begin
                        drain_done_d = 1'b1;
                    end
                end else begin
                    case ({Push, Pop})
                        2'b10: begin
                            if (!is_full) begin
                                we      = 1'b1;
                                waddr   = AW'(count_q);
                                count_d = count_q + CW'(1);
                            end else begin
                                overflow_d = 1'b1;
                            end
                        end
                        2'b01: begin
                            if (!is_empty) begin
                                pop_data_d  = mem_q[top_addr];
                                pop_valid_d = 1'b1;
                                count_d     = count_q - CW'(1);
                            end else begin
                                underflow_d = 1'b1;
                            end
                        end
                        2'b11: begin
                            pop_valid_d = 1'b1;
                            if (!is_empty) begin
                                // Replace top: old top leaves, new code takes its slot.
                                pop_data_d = mem_q[top_addr];
                                we         = 1'b1;
                                waddr      = top_addr;
                            end else begin
                                pop_data_d = PushData;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StDrain: begin
                if (Clear) begin
                    state_d       = StIdle;
                    count_d       = '0;
                    idx_d         = '0;
                    overflow_d    = 1'b0;
                    underflow_d   = 1'b0;
                    drain_valid_d = 1'b0;
                end else if (DrainReady) begin
                    if (last_entry) begin
                        state_d       = StIdle;
                        count_d       = '0;
                        idx_d         = '0;
                        drain_valid_d = 1'b0;
                        drain_done_d  = 1'b1;
                    end else begin
                        idx_d        = idx_q + AW'(1);
                        drain_data_d = mem_q[idx_q + AW'(1)];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q       <= StIdle;
            count_q       <= '0;
            idx_q         <= '0;
            pop_data_q    <= '0;
            pop_valid_q   <= 1'b0;
            drain_data_q  <= '0;
            drain_valid_q <= 1'b0;
            drain_done_q  <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            idx_q         <= idx_d;
            pop_data_q    <= pop_data_d;
            pop_valid_q   <= pop_valid_d;
            drain_data_q  <= drain_data_d;
            drain_valid_q <= drain_valid_d;
            drain_done_q  <= drain_done_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end

    // Storage contents are don't-care after reset, so no reset on the array.
    always_ff @(posedge Clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign PopData    = pop_data_q;
    assign PopValid   = pop_valid_q;
    assign DrainData  = drain_data_q;
    assign DrainValid = drain_valid_q;
    assign DrainDone  = drain_done_q;
    assign Busy       = (state_q == StDrain);
    assign Count      = count_q;
    assign Full       = is_full;
    assign Empty      = is_empty;
    assign Overflow   = overflow_q;
    assign Underflow  = underflow_q;

endmodule

// File: tb/tb_move_stack.sv
// Scoreboard bench for move_stack: stimulus queues expectations, a negedge monitor checks them.
module tb_move_stack;

    localparam int unsigned W  = 3;
    localparam int unsigned D  = 32;
    localparam int unsigned CW = 6;

    logic          Clk;
    logic          Rst_n;
    logic          Clear;
    logic          Push;
    logic [W-1:0]  PushData;
    logic          Pop;
    logic [W-1:0]  PopData;
    logic          PopValid;
    logic          Drain;
    logic [W-1:0]  DrainData;
    logic          DrainValid;
    logic          DrainReady;
    logic          DrainDone;
    logic          Busy;
    logic [CW-1:0] Count;
    logic          Full;
    logic          Empty;
    logic          Overflow;
    logic          Underflow;

    move_stack #(.W(W), .D(D)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Clear     (Clear),
        .Push      (Push),
        .PushData  (PushData),
        .Pop       (Pop),
        .PopData   (PopData),
        .PopValid  (PopValid),
        .Drain     (Drain),
        .DrainData (DrainData),
        .DrainValid(DrainValid),
        .DrainReady(DrainReady),
        .DrainDone (DrainDone),
        .Busy      (Busy),
        .Count     (Count),
        .Full      (Full),
        .Empty     (Empty),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    typedef struct {
        string name;
        int    count;
        bit    ovf;
        bit    unf;
        bit    pv;
        bit    dv;
        bit    done;
        bit    chk_pd;
        int    pd;
        bit    chk_dd;
        int    dd;
    } st_t;

    st_t      st_q[$];
    int       pop_q[$];
    int       drain_q[$];
    int       done_exp;
    int       done_seen;
    bit       finish_req;
    int       checks;
    int       errors;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        st_t e;
        while (st_q.size() > 0) begin
            e = st_q.pop_front();
            cmp({e.name, ".count"}, 32'(Count), e.count);
            cmp({e.name, ".full"}, 32'(Full), 32'(e.count == D));
            cmp({e.name, ".empty"}, 32'(Empty), 32'(e.count == 0));
            cmp({e.name, ".ovf"}, 32'(Overflow), 32'(e.ovf));
            cmp({e.name, ".unf"}, 32'(Underflow), 32'(e.unf));
            cmp({e.name, ".popvalid"}, 32'(PopValid), 32'(e.pv));
            cmp({e.name, ".drainvalid"}, 32'(DrainValid), 32'(e.dv));
            cmp({e.name, ".busy"}, 32'(Busy), 32'(e.dv));
            cmp({e.name, ".done"}, 32'(DrainDone), 32'(e.done));
            if (e.chk_pd) cmp({e.name, ".popdata"}, 32'(PopData), e.pd);
            if (e.chk_dd) cmp({e.name, ".draindata"}, 32'(DrainData), e.dd);
        end
        if (PopValid === 1'b1) begin
            if (pop_q.size() == 0) cmp("pop_unexpected", 32'(PopValid), 0);
            else cmp("pop_data", 32'(PopData), pop_q.pop_front());
        end
        if (DrainValid === 1'b1 && DrainReady === 1'b1) begin
            if (drain_q.size() == 0) cmp("drain_unexpected", 32'(DrainValid), 0);
            else cmp("drain_data", 32'(DrainData), drain_q.pop_front());
        end
        if (DrainDone === 1'b1) done_seen++;
        if (finish_req) begin
            cmp("pop_left", pop_q.size(), 0);
            cmp("drain_left", drain_q.size(), 0);
            cmp("done_pulses", done_seen, done_exp);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic expect_st(input string name, input int cnt, input bit ovf, input bit unf,
                             input bit pv, input bit dv, input bit done, input bit chk_pd,
                             input int pd, input bit chk_dd, input int dd);
        st_t e;
        e.name = name; e.count = cnt; e.ovf = ovf; e.unf = unf; e.pv = pv; e.dv = dv;
        e.done = done; e.chk_pd = chk_pd; e.pd = pd; e.chk_dd = chk_dd; e.dd = dd;
        st_q.push_back(e);
    endtask

    task automatic push(input logic [W-1:0] v);
        Push = 1'b1; PushData = v;
        cyc();
        Push = 1'b0;
    endtask

    task automatic pop(input int exp);
        pop_q.push_back(exp);
        Pop = 1'b1;
        cyc();
        Pop = 1'b0;
    endtask

    task automatic pop_empty();
        Pop = 1'b1;
        cyc();
        Pop = 1'b0;
    endtask

    task automatic push_pop(input logic [W-1:0] v, input int exp);
        pop_q.push_back(exp);
        Push = 1'b1; Pop = 1'b1; PushData = v;
        cyc();
        Push = 1'b0; Pop = 1'b0;
    endtask

    task automatic clear();
        Clear = 1'b1;
        cyc();
        Clear = 1'b0;
    endtask

    initial begin
        bit ready_pat [4];
        int dd_pat [4];
        ready_pat = '{1'b1, 1'b0, 1'b1, 1'b1};
        dd_pat    = '{2, 2, 3, 0};
        checks = 0; errors = 0; done_exp = 0; done_seen = 0; finish_req = 1'b0;
        Rst_n = 1'b0; Clear = 1'b0; Push = 1'b0; PushData = '0; Pop = 1'b0;
        Drain = 1'b0; DrainReady = 1'b0;
        cyc();
        expect_st("reset", 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        cyc();
        Rst_n = 1'b1;

        // LIFO order, back-to-back pops
        push(3'd1); push(3'd2); push(3'd3);
        expect_st("t1_pushed", 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        pop(3); pop(2); pop(1);
        expect_st("t1_popped", 0, 0, 0, 1, 0, 0, 1, 1, 0, 0);
        cyc();
        expect_st("t1_hold", 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);

        // Fill to D, then overflow
        for (int i = 0; i < 32; i++) push(3'((i * 3 + 1) % 8));
        expect_st("t2_full", 32, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(3'd7);
        expect_st("t2_ovf", 32, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        pop(6);
        expect_st("t2_pop", 31, 1, 0, 1, 0, 0, 1, 6, 0, 0);
        clear();
        expect_st("t2_clear", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Underflow, then bypass on empty
        pop_empty();
        expect_st("t3_unf", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        push_pop(3'd5, 5);
        expect_st("t3_bypass", 0, 0, 1, 1, 0, 0, 1, 5, 0, 0);
        clear();

        // Replace top
        push(3'd4); push(3'd6);
        push_pop(3'd2, 6);
        expect_st("t4_replace", 2, 0, 0, 1, 0, 0, 1, 6, 0, 0);
        pop(2); pop(4);
        expect_st("t4_done", 0, 0, 0, 1, 0, 0, 1, 4, 0, 0);

        // Drain with backpressure; pushes during drain are ignored
        push(3'd1); push(3'd2); push(3'd3);
        drain_q.push_back(1); drain_q.push_back(2); drain_q.push_back(3);
        done_exp++;
        Drain = 1'b1;
        cyc();
        Drain = 1'b0;
        expect_st("t5_start", 3, 0, 0, 0, 1, 0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            DrainReady = ready_pat[i]; Push = 1'b1; PushData = 3'd7;
            cyc();
            if (i < 3) expect_st("t5_step", 3, 0, 0, 0, 1, 0, 0, 0, 1, dd_pat[i]);
            else expect_st("t5_end", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        end
        Push = 1'b0; DrainReady = 1'b0;
        cyc();
        expect_st("t5_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Drain on empty stack
        done_exp++;
        Drain = 1'b1;
        cyc();
        Drain = 1'b0;
        expect_st("t5_empty_drain", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // Clear aborts a drain after one accepted entry
        push(3'd1); push(3'd2); push(3'd3);
        drain_q.push_back(1);
        Drain = 1'b1;
        cyc();
        Drain = 1'b0;
        DrainReady = 1'b1;
        cyc();
        expect_st("t6_mid", 3, 0, 0, 0, 1, 0, 0, 0, 1, 2);
        DrainReady = 1'b0; Clear = 1'b1;
        cyc();
        Clear = 1'b0;
        expect_st("t6_abort", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        expect_st("t6_no_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-cycle
        push(3'd6);
        pop(6);
        pop_empty();
        push(3'd2);
        expect_st("t7_pre", 1, 0, 1, 0, 0, 0, 1, 6, 0, 0);
        cyc();
        #2;
        Rst_n = 1'b0;
        expect_st("t7_async_rst", 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        cyc();
        Rst_n = 1'b1;
        finish_req = 1'b1;
    end

endmodule
